imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Boot-time controller that fills the 32-word instruction memory from a byte stream, then hands the memory read port to the core's fetch path.
- Sits between an external byte source and the instruction memory write port (WriteReg/WriteData/RegWrite).
- Owns the memory read address (Read1) and the core stall line.
- Sequences LOAD → RUN, arbitrating the read port between itself and fetch.

Parameters:
- DEPTH, 32, number of 32-bit words in the instruction memory.
- LEN_W, 6, width of load_len; must hold 0..DEPTH.
- TIMEOUT, 1024, max idle cycles between accepted bytes during LOAD before abort.

Ports:
- clock  input  1  single rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- load_start  input  1  one-cycle request to begin a load.
- load_len  input  LEN_W  word count for the load; sampled with load_start.
- byte_valid  input  1  source has a byte on byte_data.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts byte this cycle.
- pc_addr  input  32  core fetch byte address.
- mem_read_addr  output  32  to instruction memory Read1, as a word index.
- mem_write_addr  output  32  to WriteReg.
- mem_write_data  output  32  to WriteData.
- mem_write_en  output  1  to RegWrite.
- core_stall  output  1  holds the core PC/pipeline.
- load_done  output  1  level; a complete image is resident.
- load_error  output  1  one-cycle pulse on a rejected or aborted load.
- words_loaded  output  LEN_W  words written in the current or last load.

Behaviour:
- Reset (async, reset_n=0) sets:
  - state=IDLE, core_stall=1, load_done=0, load_error=0, byte_ready=0.
  - mem_write_en=0, mem_write_addr=0, mem_write_data=0, words_loaded=0.
  - byte and timeout counters=0.
- Reset mid-LOAD discards the partial word; the memory contents are not cleared.
- States: IDLE, LOAD, RUN.
- IDLE:
  - core_stall=1, mem_read_addr=0.
  - load_start with 1<=load_len<=DEPTH: latch len, clear words_loaded, go to LOAD next cycle.
  - load_start with load_len=0 or load_len>DEPTH: load_error pulses the next cycle; state stays IDLE.
- LOAD:
  - byte_ready=1, core_stall=1, load_done=0.
  - A byte is accepted on byte_valid && byte_ready.
  - Bytes assemble little-endian: the first accepted byte goes to [7:0], the fourth to [31:24].
  - After the 4th byte is accepted, in the next cycle:
    - mem_write_en=1 for exactly one cycle;
    - mem_write_addr=words_loaded (zero-extended), mem_write_data=the assembled word;
    - words_loaded increments.
  - byte_ready stays high during the write cycle, so back-to-back bytes are accepted with no bubble.
  - After the write of word len-1: go to RUN on the cycle after the write.
    - load_done=1 and core_stall=0 from the first RUN cycle.
  - The timeout counter clears on every accepted byte and increments otherwise.
    - When it reaches TIMEOUT: abort to IDLE, pulse load_error, and drop the partial word.
    - Already-written words stay in memory; words_loaded keeps its value.
  - load_start during LOAD is ignored; it does not trigger load_error.
- RUN:
  - core_stall=0, byte_ready=0.
  - mem_read_addr = {2'b00, pc_addr[31:2]}, purely combinational from pc_addr.
  - Bytes offered in RUN are not accepted.
  - load_start with a valid len: next cycle core_stall=1, load_done=0, state=LOAD.
  - load_start with an invalid len: load_error pulses; the block stays in RUN with the old image.
- Outside RUN, mem_read_addr=0.
- mem_write_en is never asserted outside the LOAD write cycle.
- Only one write per cycle.
- All outputs except mem_read_addr are registered.

Test Plan:
- Reset, then load_start with load_len=2 and bytes 13,00,A2,00 then 33,01,12,40 with valid held high.
  - Required: writes addr0=0x00A20013 and addr1=0x40120133, each one cycle after its 4th byte.
  - Required: load_done=1 and core_stall=0 the cycle after the second write; words_loaded=2.
- In RUN, drive pc_addr=0x4 → mem_read_addr=1; drive pc_addr=0x7C → mem_read_addr=31.
- load_start with load_len=0, and separately with load_len=33:
  - Required: load_error pulses once each; state unchanged; no mem_write_en.
- In LOAD with len=1, send 3 bytes then stay idle for 1024 cycles:
  - Required: load_error pulse, return to IDLE, core_stall=1, no write.
- Full load with len=32 and random byte_valid gaps:
  - Required: 32 writes at addresses 0..31 with correct data; words_loaded=32.
- Assert reset_n=0 mid-word during LOAD:
  - Required: immediate return to reset values.
  - Required: a new load afterwards starts at addr0 with byte lane [7:0].

Source files
------------

// File: rtl/imem_boot_loader_if.sv
// Bundles the boot loader's control, byte-stream and instruction-memory signals.
// The slave modport is the loader; the master modport is the surrounding system.
interface imem_boot_loader_if #(
    parameter int LEN_W = 6
);
    logic             load_start;
    logic [LEN_W-1:0] load_len;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic [31:0]      pc_addr;
    logic [31:0]      mem_read_addr;
    logic [31:0]      mem_write_addr;
    logic [31:0]      mem_write_data;
    logic             mem_write_en;
    logic             core_stall;
    logic             load_done;
    logic             load_error;
    logic [LEN_W-1:0] words_loaded;

    modport slave (
        input  load_start, load_len, byte_valid, byte_data, pc_addr,
        output byte_ready, mem_read_addr, mem_write_addr, mem_write_data,
               mem_write_en, core_stall, load_done, load_error, words_loaded
    );

    modport master (
        output load_start, load_len, byte_valid, byte_data, pc_addr,
        input  byte_ready, mem_read_addr, mem_write_addr, mem_write_data,
               mem_write_en, core_stall, load_done, load_error, words_loaded
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot-time loader: assembles a little-endian byte stream into instruction-memory
// words, then releases the core and hands the memory read port to instruction fetch.
module imem_boot_loader #(
    parameter int DEPTH   = 32,
    parameter int LEN_W   = 6,
    parameter int TIMEOUT = 1024
) (
    input  logic               clock,
    input  logic               reset_n,
    imem_boot_loader_if.slave  bus
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic             err_s;
    logic             start_load_s;
    logic             len_ok_s;
    logic             abort_s;
    logic             accept_s;
    logic [31:0]      word_s;
    logic             pc_unused_s;

    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] words_loaded_r;
    logic [1:0]       byte_cnt_r;
    logic [31:0]      word_buf_r;
    logic [TMO_W-1:0] tmo_r;
    logic             wr_en_r;
    logic [31:0]      wr_addr_r;
    logic [31:0]      wr_data_r;
    logic             ready_r;
    logic             stall_r;
    logic             done_r;
    logic             err_r;

    assign len_ok_s    = (bus.load_len != {LEN_W{1'b0}}) && (bus.load_len <= LEN_W'(DEPTH));
    assign abort_s     = (state_r == ST_LOAD) && (tmo_r == TMO_W'(TIMEOUT));
    assign accept_s    = bus.byte_valid && ready_r && (state_r == ST_LOAD) && !abort_s;
    // Bytes shift in from the top so the first accepted byte lands in [7:0].
    assign word_s      = {bus.byte_data, word_buf_r[31:8]};
    assign pc_unused_s = &{1'b0, bus.pc_addr[1:0]};

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode, load-request validation and error detection.
    always_comb begin
        next_state_s = state_r;
        err_s        = 1'b0;
        start_load_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_RUN: begin
                if (bus.load_start) begin
                    if (len_ok_s) begin
                        next_state_s = ST_LOAD;
                        start_load_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_LOAD: begin
                if (abort_s) begin
                    next_state_s = ST_IDLE;
                    err_s        = 1'b1;
                end else if (wr_en_r && (words_loaded_r == len_r)) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_r <= 1'b0;
            stall_r <= 1'b1;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            ready_r <= (next_state_s == ST_LOAD);
            stall_r <= (next_state_s != ST_RUN);
            done_r  <= (next_state_s == ST_RUN);
            err_r   <= err_s;
        end
    end

    // Byte assembly, idle timeout and the single-cycle memory write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            len_r          <= {LEN_W{1'b0}};
            words_loaded_r <= {LEN_W{1'b0}};
            byte_cnt_r     <= 2'd0;
            word_buf_r     <= 32'd0;
            tmo_r          <= {TMO_W{1'b0}};
            wr_en_r        <= 1'b0;
            wr_addr_r      <= 32'd0;
            wr_data_r      <= 32'd0;
        end else if (start_load_s) begin
            len_r          <= bus.load_len;
            words_loaded_r <= {LEN_W{1'b0}};
            byte_cnt_r     <= 2'd0;
            tmo_r          <= {TMO_W{1'b0}};
            wr_en_r        <= 1'b0;
        end else if (state_r == ST_LOAD && !abort_s) begin
            if (accept_s) begin
                tmo_r      <= {TMO_W{1'b0}};
                byte_cnt_r <= byte_cnt_r + 2'd1;
                word_buf_r <= word_s;
                if (byte_cnt_r == 2'd3) begin
                    wr_en_r        <= 1'b1;
                    wr_addr_r      <= {{(32-LEN_W){1'b0}}, words_loaded_r};
                    wr_data_r      <= word_s;
                    words_loaded_r <= words_loaded_r + LEN_W'(1);
                end else begin
                    wr_en_r <= 1'b0;
                end
            end else begin
                tmo_r   <= tmo_r + TMO_W'(1);
                wr_en_r <= 1'b0;
            end
        end else begin
            // Leaving LOAD (abort or completion) drops any partial word.
            byte_cnt_r <= 2'd0;
            tmo_r      <= {TMO_W{1'b0}};
            wr_en_r    <= 1'b0;
        end
    end

    assign bus.mem_read_addr  = (state_r == ST_RUN) ? {2'b00, bus.pc_addr[31:2]} : 32'd0;
    assign bus.byte_ready     = ready_r;
    assign bus.core_stall     = stall_r;
    assign bus.load_done      = done_r;
    assign bus.load_error     = err_r;
    assign bus.mem_write_en   = wr_en_r;
    assign bus.mem_write_addr = wr_addr_r;
    assign bus.mem_write_data = wr_data_r;
    assign bus.words_loaded   = words_loaded_r;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes are queued as each word's
// last byte is handed over and matched against the memory write port.
module tb_imem_boot_loader;
    logic clock;
    logic reset_n;
    int   n_vec;
    int   n_err;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    wr_exp_t sb_q[$];

    imem_boot_loader_if #(.LEN_W(6)) bus ();

    imem_boot_loader #(.DEPTH(32), .LEN_W(6), .TIMEOUT(1024)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // A write must appear exactly in the cycle after each expected word was accepted.
    always @(negedge clock) begin
        if (reset_n && (bus.mem_write_en || sb_q.size() > 0)) begin
            chk("wr_en", {31'd0, bus.mem_write_en}, 32'd1);
            if (bus.mem_write_en && sb_q.size() > 0) begin
                wr_exp_t e;
                e = sb_q.pop_front();
                chk("wr_addr", bus.mem_write_addr, e.addr);
                chk("wr_data", bus.mem_write_data, e.data);
            end else if (sb_q.size() > 0) begin
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_stall"}, {31'd0, bus.core_stall}, 32'd1);
        chk({tag, "_done"},  {31'd0, bus.load_done}, 32'd0);
        chk({tag, "_err"},   {31'd0, bus.load_error}, 32'd0);
        chk({tag, "_rdy"},   {31'd0, bus.byte_ready}, 32'd0);
        chk({tag, "_wen"},   {31'd0, bus.mem_write_en}, 32'd0);
        chk({tag, "_waddr"}, bus.mem_write_addr, 32'd0);
        chk({tag, "_wdata"}, bus.mem_write_data, 32'd0);
        chk({tag, "_words"}, {26'd0, bus.words_loaded}, 32'd0);
        chk({tag, "_raddr"}, bus.mem_read_addr, 32'd0);
    endtask

    // Called at a drive point (#1 after a rising edge); returns at the same kind of point.
    task automatic start_load(input logic [5:0] len);
        bus.load_start = 1'b1;
        bus.load_len   = len;
        @(posedge clock);
        #1;
        bus.load_start = 1'b0;
    endtask

    // Presents one byte after an optional gap; returns at the accepting rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic r;
        logic acc;
        if (gap > 0) begin
            bus.byte_valid = 1'b0;
            repeat (gap) @(posedge clock);
            #1;
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        acc = 1'b0;
        for (int i = 0; i < 2000 && !acc; i++) begin
            @(negedge clock);
            r = bus.byte_ready;
            @(posedge clock);
            acc = r;
        end
        if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] addr, input logic [31:0] w, input int max_gap);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] wv;
            wv = w >> (8 * k);
            send_byte(wv[7:0], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
            if (k == 3) sb_q.push_back('{addr: addr, data: w});
            #1;
            bus.byte_valid = 1'b0;
        end
    endtask

    initial begin
        int cnt;
        logic seen;
        logic [31:0] w;
        n_vec = 0;
        n_err = 0;
        reset_n        = 1'b0;
        bus.load_start = 1'b0;
        bus.load_len   = 6'd0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'd0;
        bus.pc_addr    = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_vals("rst");
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Two-word load with the stream held back-to-back.
        start_load(6'd2);
        chk("load_rdy",   {31'd0, bus.byte_ready}, 32'd1);
        chk("load_stall", {31'd0, bus.core_stall}, 32'd1);
        send_word(32'd0, 32'h00A2_0013, 0);
        send_word(32'd1, 32'h4012_0133, 0);
        @(posedge clock);
        @(negedge clock);
        chk("run_done",  {31'd0, bus.load_done}, 32'd1);
        chk("run_stall", {31'd0, bus.core_stall}, 32'd0);
        chk("run_words", {26'd0, bus.words_loaded}, 32'd2);
        chk("run_rdy",   {31'd0, bus.byte_ready}, 32'd0);

        // Fetch address translation in RUN.
        bus.pc_addr = 32'h0000_0004;
        #1;
        chk("raddr_4", bus.mem_read_addr, 32'd1);
        bus.pc_addr = 32'h0000_007C;
        #1;
        chk("raddr_7c", bus.mem_read_addr, 32'd31);
        bus.pc_addr = 32'hFFFF_FFFF;
        #1;
        chk("raddr_max", bus.mem_read_addr, 32'h3FFF_FFFF);

        // Rejected lengths in RUN: one error pulse each, image stays live.
        @(posedge clock);
        #1;
        start_load(6'd0);
        @(negedge clock);
        chk("len0_err",   {31'd0, bus.load_error}, 32'd1);
        chk("len0_done",  {31'd0, bus.load_done}, 32'd1);
        @(negedge clock);
        chk("len0_pulse", {31'd0, bus.load_error}, 32'd0);
        @(posedge clock);
        #1;
        start_load(6'd33);
        @(negedge clock);
        chk("len33_err",   {31'd0, bus.load_error}, 32'd1);
        chk("len33_stall", {31'd0, bus.core_stall}, 32'd0);
        @(negedge clock);
        chk("len33_pulse", {31'd0, bus.load_error}, 32'd0);
        chk("len33_words", {26'd0, bus.words_loaded}, 32'd2);

        // Timeout: three bytes then silence.
        @(posedge clock);
        #1;
        start_load(6'd1);
        send_byte(8'hAA, 0);
        #1;
        send_byte(8'hBB, 0);
        #1;
        send_byte(8'hCC, 0);
        #1;
        bus.byte_valid = 1'b0;
        seen = 1'b0;
        cnt  = 0;
        for (int i = 1; i <= 1100 && !seen; i++) begin
            @(negedge clock);
            if (bus.load_error) begin
                seen = 1'b1;
                cnt  = i;
            end
        end
        chk("tmo_err",    {31'd0, seen}, 32'd1);
        chk("tmo_window", {31'd0, (cnt >= 1024 && cnt <= 1026)}, 32'd1);
        chk("tmo_stall",  {31'd0, bus.core_stall}, 32'd1);
        chk("tmo_rdy",    {31'd0, bus.byte_ready}, 32'd0);
        chk("tmo_done",   {31'd0, bus.load_done}, 32'd0);
        chk("tmo_raddr",  bus.mem_read_addr, 32'd0);
        @(negedge clock);
        chk("tmo_pulse",  {31'd0, bus.load_error}, 32'd0);

        // Full 32-word image with random stream gaps.
        @(posedge clock);
        #1;
        start_load(6'd32);
        for (int a = 0; a < 32; a++) begin
            w = $urandom;
            send_word(32'(a), w, 3);
        end
        @(posedge clock);
        @(negedge clock);
        chk("full_words", {26'd0, bus.words_loaded}, 32'd32);
        chk("full_done",  {31'd0, bus.load_done}, 32'd1);
        chk("full_sb",    32'(sb_q.size()), 32'd0);

        // Reset in the middle of a word, then a fresh load from address 0.
        @(posedge clock);
        #1;
        start_load(6'd2);
        send_byte(8'h55, 0);
        #1;
        send_byte(8'h66, 0);
        #1;
        bus.byte_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        start_load(6'd1);
        send_word(32'd0, 32'h1122_3344, 0);
        @(posedge clock);
        @(negedge clock);
        chk("post_rst_done",  {31'd0, bus.load_done}, 32'd1);
        chk("post_rst_words", {26'd0, bus.words_loaded}, 32'd1);
        chk("post_rst_sb",    32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d miscompares %0d", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end
endmodule
